// File: rtl/lc3_sram_responder_pkg.sv
// Shared types and constants for the LC-3 SRAM strobe responder.
package lc3_sram_responder_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned READ_LAT_MIN  = 2;
    localparam int unsigned READ_LAT_MAX  = 7;
    localparam int unsigned WRITE_LAT_MIN = 1;
    localparam int unsigned WRITE_LAT_MAX = 7;
    localparam int unsigned CNT_W         = 3;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_WR_HOLD
    } state_e;

    // Active-low UB/LB strobes to an active-high {hi, lo} byte mask.
    function automatic logic [1:0] byte_mask(input logic ub_n, input logic lb_n);
        return {~ub_n, ~lb_n};
    endfunction

endpackage

// File: rtl/lc3_sram_responder_sram_byte_array.sv
// Single-port word array with per-byte write enables and a masked, registered read.
module sram_byte_array
    import lc3_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        we_i,
    input  logic              re_i,
    input  logic [1:0]        rmask_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0]        mem_hi [DEPTH];
    logic [7:0]        mem_lo [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i[1]) mem_hi[addr_i] <= wdata_i[15:8];
        if (we_i[0]) mem_lo[addr_i] <= wdata_i[7:0];
    end

    // Read register only updates on a load strobe so the last word is held.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= {rmask_i[1] ? mem_hi[addr_i] : 8'h00,
                        rmask_i[0] ? mem_lo[addr_i] : 8'h00};
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lc3_sram_responder.sv
// LC-3 SRAM strobe responder: fixed-latency CPU read/write, loader port, clear-on-reset.
module lc3_sram_responder
    import lc3_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic [15:0]       ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Data_valid,
    output logic              Init_busy,
    input  logic              Init_we,
    input  logic [ADDR_W-1:0] Init_addr,
    input  logic [DATA_W-1:0] Init_data,
    output logic              Init_stall,
    output logic              Err_protocol
);

    localparam int unsigned RL = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                                 (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;
    localparam int unsigned WL = (WRITE_LAT < WRITE_LAT_MIN) ? WRITE_LAT_MIN :
                                 (WRITE_LAT > WRITE_LAT_MAX) ? WRITE_LAT_MAX : WRITE_LAT;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   clr_q, clr_d;
    logic [ADDR_W-1:0]   lat_q, lat_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic                sel, rd, wr, conflict, same_addr;
    logic [ADDR_W-1:0]   addr_w;
    logic [1:0]          mask_c;
    logic [1:0]          arr_we, arr_we_g;
    logic                arr_re;
    logic [ADDR_W-1:0]   arr_addr;
    logic [DATA_W-1:0]   arr_wdata;
    logic                init_stall_c;
    logic                unused_addr_hi;

    assign sel            = ~Mem_CE;
    assign rd             = sel & ~Mem_OE & Mem_WE;
    assign wr             = sel & ~Mem_WE & Mem_OE;
    assign conflict       = sel & ~Mem_OE & ~Mem_WE;
    assign addr_w         = ADDR[ADDR_W-1:0];
    assign same_addr      = (addr_w == lat_q);
    assign mask_c         = byte_mask(Mem_UB, Mem_LB);
    assign unused_addr_hi = &{1'b0, ADDR[15:ADDR_W]};

    // Next-state logic and array port mux (clear / CPU / loader).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        clr_d        = clr_q;
        lat_d        = lat_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        arr_we       = 2'b00;
        arr_re       = 1'b0;
        arr_addr     = addr_w;
        arr_wdata    = Data_from_CPU;
        init_stall_c = 1'b1;

        case (state_q)
            ST_CLEAR: begin
                arr_we    = 2'b11;
                arr_addr  = clr_q;
                arr_wdata = '0;
                clr_d     = clr_q + ADDR_W'(1);
                if (clr_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (conflict) begin
                    err_d = 1'b1;
                end else if (rd) begin
                    state_d = ST_READ;
                    cnt_d   = CNT_W'(1);
                    lat_d   = addr_w;
                    if (RL == 2) begin
                        arr_re  = 1'b1;
                        valid_d = 1'b1;
                    end
                end else if (wr) begin
                    lat_d = addr_w;
                    if (WL == 1) begin
                        arr_we  = mask_c;
                        state_d = ST_WR_HOLD;
                    end else begin
                        state_d = ST_WRITE;
                        cnt_d   = CNT_W'(1);
                    end
                end else begin
                    init_stall_c = 1'b0;
                    if (Init_we) begin
                        arr_we    = 2'b11;
                        arr_addr  = Init_addr;
                        arr_wdata = Init_data;
                    end
                end
            end
            ST_READ: begin
                if (conflict) begin
                    err_d = 1'b1;
                    cnt_d = CNT_W'(1);
                    lat_d = addr_w;
                end else if (!rd) begin
                    state_d = ST_IDLE;
                end else if (!same_addr) begin
                    // Restart as a fresh first cycle at the new address.
                    err_d = 1'b1;
                    cnt_d = CNT_W'(1);
                    lat_d = addr_w;
                    if (RL == 2) begin
                        arr_re  = 1'b1;
                        valid_d = 1'b1;
                    end
                end else begin
                    valid_d = valid_q;
                    if (cnt_q == CNT_W'(RL - 2)) begin
                        arr_re  = 1'b1;
                        valid_d = 1'b1;
                    end
                    if (cnt_q != CNT_W'(RL)) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (!wr || !same_addr) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(WL - 1)) begin
                    arr_we   = mask_c;
                    arr_addr = lat_q;
                    state_d  = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                if (!wr) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CLEAR);
    end

    // A reset edge must never commit a partial write.
    assign arr_we_g = Reset ? 2'b00 : arr_we;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            clr_q   <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    sram_byte_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .we_i    (arr_we_g),
        .re_i    (arr_re),
        .rmask_i (mask_c),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (Data_to_CPU)
    );

    assign Data_valid   = valid_q;
    assign Err_protocol = err_q;
    assign Init_busy    = busy_q;
    assign Init_stall   = init_stall_c;

endmodule

// File: tb/tb_lc3_sram_responder.sv
// Directed self-checking bench for lc3_sram_responder (default parameters).
module tb_lc3_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Mem_CE = 1'b1, Mem_OE = 1'b1, Mem_WE = 1'b1, Mem_UB = 1'b0, Mem_LB = 1'b0;
    logic [15:0] ADDR = '0, Data_from_CPU = '0;
    logic [15:0] Data_to_CPU;
    logic        Data_valid, Init_busy, Init_stall, Err_protocol;
    logic        Init_we = 1'b0;
    logic [9:0]  Init_addr = '0;
    logic [15:0] Init_data = '0;

    int checks = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    lc3_sram_responder dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Mem_CE        (Mem_CE),
        .Mem_OE        (Mem_OE),
        .Mem_WE        (Mem_WE),
        .Mem_UB        (Mem_UB),
        .Mem_LB        (Mem_LB),
        .ADDR          (ADDR),
        .Data_from_CPU (Data_from_CPU),
        .Data_to_CPU   (Data_to_CPU),
        .Data_valid    (Data_valid),
        .Init_busy     (Init_busy),
        .Init_we       (Init_we),
        .Init_addr     (Init_addr),
        .Init_data     (Init_data),
        .Init_stall    (Init_stall),
        .Err_protocol  (Err_protocol)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_bus();
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Mem_UB = 1'b0; Mem_LB = 1'b0;
    endtask

    // Two-cycle OE-low read; returns valid in cycles 1 and 2 and the data in cycle 2.
    task automatic cpu_read(input logic [15:0] a, input logic ub, input logic lb,
                            output logic [15:0] d, output logic v1, output logic v2);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; Mem_UB = ub; Mem_LB = lb; ADDR = a;
        @(negedge Clk); v1 = Data_valid;
        tick();
        @(negedge Clk); v2 = Data_valid; d = Data_to_CPU;
        tick();
        idle_bus();
        tick();
    endtask

    // WE low for n cycles, then a few idle cycles; reports any Err_protocol pulse seen.
    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d, input logic ub,
                             input logic lb, input int n, output logic err);
        err = 1'b0;
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = ub; Mem_LB = lb;
        ADDR = a; Data_from_CPU = d;
        repeat (n) begin @(negedge Clk); err |= Err_protocol; tick(); end
        idle_bus();
        repeat (3) begin @(negedge Clk); err |= Err_protocol; tick(); end
    endtask

    task automatic loader_write(input logic [9:0] a, input logic [15:0] d, output logic stall);
        Init_we = 1'b1; Init_addr = a; Init_data = d;
        @(negedge Clk); stall = Init_stall;
        tick();
        Init_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic v1, v2;
        int n;
        Reset = 1'b1; idle_bus();
        tick(); tick();
        @(negedge Clk);
        checks++; if (Init_busy !== 1'b1) begin failures++; $display("FAIL rst_busy: got %b expected 1", Init_busy); end
        checks++; if (Init_stall !== 1'b1) begin failures++; $display("FAIL rst_stall: got %b expected 1", Init_stall); end
        checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL rst_data: got %h expected 0000", Data_to_CPU); end
        checks++; if (Data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b expected 0", Data_valid); end
        checks++; if (Err_protocol !== 1'b0) begin failures++; $display("FAIL rst_err: got %b expected 0", Err_protocol); end
        Reset = 1'b0;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (Init_busy !== 1'b1) break;
            n++;
            @(negedge Clk);
        end
        checks++; if (n != 1024) begin failures++; $display("FAIL clear_cycles: got %0d expected 1024", n); end
        checks++; if (Init_stall !== 1'b0) begin failures++; $display("FAIL idle_stall: got %b expected 0", Init_stall); end
        tick();
        cpu_read(16'h03FF, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL clear_read_3ff: got %h expected 0000", d); end
        checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL clear_read_valid: got %b expected 1", v2); end
        cpu_read(16'h0200, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL clear_read_200: got %h expected 0000", d); end
    endtask

    task automatic test_loader_read();
        logic [15:0] d;
        logic v1, v2, st;
        loader_write(10'h005, 16'h1234, st);
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL loader_stall: got %b expected 0", st); end
        cpu_read(16'h0005, 1'b0, 1'b0, d, v1, v2);
        checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL read_valid_c1: got %b expected 0", v1); end
        checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL read_valid_c2: got %b expected 1", v2); end
        checks++; if (d !== 16'h1234) begin failures++; $display("FAIL read_data: got %h expected 1234", d); end
        cpu_read(16'h0405, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h1234) begin failures++; $display("FAIL read_alias: got %h expected 1234", d); end
    endtask

    task automatic test_byte_write();
        logic [15:0] d;
        logic v1, v2, e;
        cpu_write(16'h0010, 16'hBEEF, 1'b1, 1'b0, 2, e);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL lo_write_err: got %b expected 0", e); end
        cpu_read(16'h0010, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h00EF) begin failures++; $display("FAIL lo_write_data: got %h expected 00ef", d); end
        cpu_write(16'h0010, 16'hBEEF, 1'b0, 1'b0, 2, e);
        cpu_read(16'h0010, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'hBEEF) begin failures++; $display("FAIL full_write_data: got %h expected beef", d); end
        cpu_read(16'h0010, 1'b0, 1'b1, d, v1, v2);
        checks++; if (d !== 16'hBE00) begin failures++; $display("FAIL hi_read_mask: got %h expected be00", d); end
    endtask

    task automatic test_short_write();
        logic [15:0] d;
        logic v1, v2, e;
        cpu_write(16'h0020, 16'h5555, 1'b0, 1'b0, 1, e);
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL short_write_err: got %b expected 1", e); end
        cpu_read(16'h0020, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL short_write_data: got %h expected 0000", d); end
    endtask

    task automatic test_conflict();
        logic [15:0] d;
        logic v1, v2, st, e, s1, s2, s3, s4;
        loader_write(10'h030, 16'hA5A5, st);
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0030; Data_from_CPU = 16'hFFFF;
        tick();
        idle_bus();
        @(negedge Clk); e = Err_protocol;
        tick();
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL conflict_err: got %b expected 1", e); end
        cpu_read(16'h0030, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'hA5A5) begin failures++; $display("FAIL conflict_nochange: got %h expected a5a5", d); end
        // Loader request held across a CPU read.
        Mem_CE = 1'b0; Mem_OE = 1'b0; Mem_WE = 1'b1; ADDR = 16'h0005;
        Init_we = 1'b1; Init_addr = 10'h040; Init_data = 16'h7777;
        @(negedge Clk); s1 = Init_stall;
        tick();
        @(negedge Clk); s2 = Init_stall; d = Data_to_CPU;
        tick();
        idle_bus();
        @(negedge Clk); s3 = Init_stall;
        tick();
        @(negedge Clk); s4 = Init_stall;
        tick();
        Init_we = 1'b0;
        checks++; if ({s1, s2, s3} !== 3'b111) begin failures++; $display("FAIL stall_during_read: got %b expected 111", {s1, s2, s3}); end
        checks++; if (s4 !== 1'b0) begin failures++; $display("FAIL stall_after_read: got %b expected 0", s4); end
        checks++; if (d !== 16'h1234) begin failures++; $display("FAIL read_with_loader: got %h expected 1234", d); end
        cpu_read(16'h0040, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h7777) begin failures++; $display("FAIL deferred_loader: got %h expected 7777", d); end
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] d;
        logic v1, v2;
        cpu_read(16'h0005, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h1234) begin failures++; $display("FAIL pre_reset_read: got %h expected 1234", d); end
        Mem_CE = 1'b0; Mem_OE = 1'b1; Mem_WE = 1'b0; Mem_UB = 1'b0; Mem_LB = 1'b0;
        ADDR = 16'h0050; Data_from_CPU = 16'h9999;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        idle_bus();
        @(negedge Clk);
        checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL midwr_rst_data: got %h expected 0000", Data_to_CPU); end
        checks++; if (Init_busy !== 1'b1) begin failures++; $display("FAIL midwr_rst_busy: got %b expected 1", Init_busy); end
        for (int i = 0; i < 2000 && Init_busy === 1'b1; i++) @(negedge Clk);
        checks++; if (Init_busy !== 1'b0) begin failures++; $display("FAIL midwr_clear_done: got %b expected 0", Init_busy); end
        tick();
        cpu_read(16'h0050, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midwr_no_commit: got %h expected 0000", d); end
        cpu_read(16'h0005, 1'b0, 1'b0, d, v1, v2);
        checks++; if (d !== 16'h0000) begin failures++; $display("FAIL midwr_recleared: got %h expected 0000", d); end
    endtask

    initial begin
        test_reset();
        test_loader_read();
        test_byte_write();
        test_short_write();
        test_conflict();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
